div_unit: RTL and testbench

Multicycle signed divider for the MIPS datapath, driven by the control unit's DivCtrl strobe for the DIV instruction.
- Operands come from the register-file A/B latches (rs, rt).
- Runs a 32-iteration restoring division on operand magnitudes, then applies a sign fix.
- Writes quotient to LO and remainder to HI.
- Reports completion or divide-by-zero back to the control unit, which waits in its DIV state and branches to the exception path on div_zero.

---
 rtl/div_unit_pkg.sv | 22 ++
 rtl/div_step.sv | 22 ++
 rtl/div_unit.sv | 117 +++++++++++
 tb/tb_div_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle divider and the control unit that drives it.
// Holds the divider FSM encoding, iteration bounds and the DivCtrl/MultCtrl strobe values.
package div_unit_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;
    localparam int ITER_LAST = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Strobe levels issued by the control unit towards the mult/div blocks.
    localparam logic DIVCTRL_IDLE   = 1'b0;
    localparam logic DIVCTRL_START  = 1'b1;
    localparam logic MULTCTRL_IDLE  = 1'b0;
    localparam logic MULTCTRL_START = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// try to subtract the divisor, keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor holds on entry, so WIDTH+1 bits are enough and the MSB is the borrow.
    assign shifted  = {rem, dvd_msb};
    assign trial    = shifted - {1'b0, divisor};
    assign q_bit    = ~trial[WIDTH];
    assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider for DIV: restoring division on magnitudes, then sign fix.
// Quotient lands in LO, remainder in HI; done / div_zero report back to the control unit.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    logic [WIDTH-1:0] rem_d;
    logic             q_bit_d;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Two's-complement negation of the most negative value wraps to itself,
    // which is exactly its unsigned magnitude.
    assign abs_a = A[WIDTH-1] ? -A : A;
    assign abs_b = B[WIDTH-1] ? -B : B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (rem_d),
        .q_bit    (q_bit_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (DivCtrl == DIVCTRL_START) begin
                        if (B == '0) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            dvd_q    <= abs_a;
                            dvs_q    <= abs_b;
                            sign_q_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            sign_r_q <= A[WIDTH-1];
                            rem_q    <= '0;
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], q_bit_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= SIGN;
                    end
                end
                SIGN: begin
                    lo_q    <= sign_q_q ? -dvd_q : dvd_q;
                    hi_q    <= sign_r_q ? -rem_q : rem_q;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus randomized operands
// compared against a plain-arithmetic signed division model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        DivCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .DivCtrl  (DivCtrl),
        .A        (A),
        .B        (B),
        .HI       (HI),
        .LO       (LO),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Reference: signed division truncating toward zero, remainder follows dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        DivCtrl = 1'b1;
        @(posedge clk);
        #1;
        DivCtrl = 1'b0;
    endtask

    // Counts edges after the start edge until done; 60 means it never came.
    task automatic wait_done(output int k, output bit dz);
        k = 0;
        dz = div_zero;
        while (!done && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (div_zero) dz = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        DivCtrl = 1'b0;
        A = '0;
        B = '0;
        #1;
        n_cmp++;
        if ({HI, LO, busy, done, div_zero} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_state: got HI=%h LO=%h busy=%b done=%b dz=%b, want all 0",
                     HI, LO, busy, done, div_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_timing();
        int busy_cnt, done_k, done_cnt;
        bit dz;
        start(32'd100, 32'd7);
        busy_cnt = busy ? 1 : 0;
        done_k = -1;
        done_cnt = 0;
        dz = div_zero;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (div_zero) dz = 1'b1;
        end
        n_cmp++;
        if (done_k != 34 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL basic_latency: done at edge %0d (%0d pulses), want edge 34 (1 pulse)", done_k, done_cnt);
        end
        n_cmp++;
        if (busy_cnt != 33) begin
            n_bad++;
            $display("FAIL basic_busy: busy high %0d cycles, want 33", busy_cnt);
        end
        n_cmp++;
        if (LO !== 32'd14 || HI !== 32'd2 || dz) begin
            n_bad++;
            $display("FAIL basic_result: LO=%0d HI=%0d dz=%b, want LO=14 HI=2 dz=0", LO, HI, dz);
        end
    endtask

    task automatic test_signs();
        logic [31:0] ta [4] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'd0};
        logic [31:0] tb [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd5};
        logic [63:0] exp;
        int k;
        bit dz;
        for (int i = 0; i < 4; i++) begin
            start(ta[i], tb[i]);
            wait_done(k, dz);
            exp = ref_div(ta[i], tb[i]);
            n_cmp++;
            if (k != 34 || LO !== exp[31:0] || HI !== exp[63:32] || dz) begin
                n_bad++;
                $display("FAIL signs[%0d]: k=%0d LO=%h HI=%h dz=%b, want k=34 LO=%h HI=%h dz=0",
                         i, k, LO, HI, dz, exp[31:0], exp[63:32]);
            end
        end
    endtask

    task automatic test_div_zero();
        int k;
        bit dz, seen_done, seen_busy;
        start(32'd95, 32'd10);
        wait_done(k, dz);
        n_cmp++;
        if (LO !== 32'd9 || HI !== 32'd5) begin
            n_bad++;
            $display("FAIL dz_setup: LO=%0d HI=%0d, want LO=9 HI=5", LO, HI);
        end
        @(posedge clk);
        #1;
        start(32'd5, 32'd0);
        n_cmp++;
        if (div_zero !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL dz_pulse: dz=%b done=%b busy=%b, want 1 0 0", div_zero, done, busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL dz_width: dz=%b one cycle later, want 0", div_zero);
        end
        seen_done = 1'b0;
        seen_busy = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
        end
        n_cmp++;
        if (seen_done || seen_busy || LO !== 32'd9 || HI !== 32'd5) begin
            n_bad++;
            $display("FAIL dz_hold: done_seen=%b busy_seen=%b LO=%0d HI=%0d, want 0 0 9 5",
                     seen_done, seen_busy, LO, HI);
        end
    endtask

    task automatic test_overflow();
        int k;
        bit dz;
        start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(k, dz);
        n_cmp++;
        if (k != 34 || LO !== 32'h8000_0000 || HI !== 32'h0 || dz) begin
            n_bad++;
            $display("FAIL overflow: k=%0d LO=%h HI=%h dz=%b, want k=34 LO=80000000 HI=0 dz=0", k, LO, HI, dz);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        bit dz;
        start(32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        A = 32'd1;
        B = 32'd1;
        DivCtrl = 1'b1;
        @(posedge clk);
        #1;
        DivCtrl = 1'b0;
        A = 32'hDEAD_BEEF;
        B = 32'd0;
        wait_done(k, dz);
        n_cmp++;
        if (k + 5 != 34 || LO !== 32'd14 || HI !== 32'd2 || dz) begin
            n_bad++;
            $display("FAIL ignore_busy: k=%0d LO=%0d HI=%0d dz=%b, want k=29 LO=14 HI=2 dz=0", k, LO, HI, dz);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bit dz;
        start(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: HI=%h LO=%h busy=%b done=%b, want all 0", HI, LO, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        start(32'd9, 32'd3);
        wait_done(k, dz);
        n_cmp++;
        if (k != 34 || LO !== 32'd3 || HI !== 32'd0 || dz) begin
            n_bad++;
            $display("FAIL after_reset: k=%0d LO=%0d HI=%0d dz=%b, want k=34 LO=3 HI=0 dz=0", k, LO, HI, dz);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [63:0] exp;
        int k;
        bit dz;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 5)
                1: b = $urandom_range(1, 20);
                2: b = -$urandom_range(1, 20);
                3: a = (i % 2) ? 32'h8000_0000 : 32'd0;
                default: ;
            endcase
            if (b == 32'd0) b = 32'd1;
            start(a, b);
            wait_done(k, dz);
            exp = ref_div(a, b);
            n_cmp++;
            if (k != 34 || LO !== exp[31:0] || HI !== exp[63:32] || dz) begin
                n_bad++;
                $display("FAIL random[%0d] %h/%h: k=%0d LO=%h HI=%h dz=%b, want k=34 LO=%h HI=%h",
                         i, a, b, k, LO, HI, dz, exp[31:0], exp[63:32]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_signs();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
